ps2_keyboard_receiver: RTL and testbench

Deserialises PS/2 keyboard frames from the external `ps2_clk`/`ps2_data` pins and exposes the latest key event as the 32-bit `ps2_read` word. The address decoder returns this word to the ARMv4 core on a PS/2 address read. The block also drives a level output that tracks the held state of the flap key, so game logic can poll a single bit. It owns break/extended prefix tracking, odd-parity checking, frame timeout and a read-acknowledge handshake.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_keyboard_receiver.sv | 107 ++++++++++
 tb/tb_ps2_keyboard_receiver.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, status-word bit positions and scan-code prefixes
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int PS2_BREAK_BIT   = 8;
    localparam int PS2_EXT_BIT     = 9;
    localparam int PS2_VALID_BIT   = 10;
    localparam int PS2_OVERRUN_BIT = 11;
    localparam int PS2_FERR_BIT    = 12;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises the PS/2 pins and flags falling edges of the PS/2 clock
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data,
    output logic fall
);
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic clk_prev;
    // flops reset high so an idle bus never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end
    assign data = data_sync[SYNC_STAGES-1];
    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_keyboard_receiver.sv
// ps2_keyboard_receiver: PS/2 frame FSM with prefix tracking, parity, timeout
// and a read-acknowledged status word, plus a held-key level for FLAP_CODE.
module ps2_keyboard_receiver
    import ps2_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] FLAP_CODE      = 8'h29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        read_ack,
    output logic [31:0] ps2_read,
    output logic        flap_held
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    state_t state, next;
    logic data_s, fall;
    logic [2:0] bit_cnt;
    logic [7:0] shift, code;
    logic [TW-1:0] timer;
    logic par_bit, brk_pend, ext_pend, brk, ext, valid, overrun, ferr;
    logic timeout, stop_edge, good, bad, publish;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data_s), .fall(fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        if (timeout) next = IDLE;
        else if (fall) begin
            case (state)
                IDLE:    next = data_s ? IDLE : DATA;
                DATA:    next = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  next = STOP;
                default: next = IDLE;
            endcase
        end
    end

    always_comb begin
        timeout   = (state != IDLE) && (timer == TW'(TIMEOUT_CYCLES - 1));
        stop_edge = (state == STOP) && fall && !timeout;
        good      = stop_edge && data_s && (^{shift, par_bit});
        bad       = (stop_edge && !good) || timeout;
        publish   = good && (shift != PS2_BREAK) && (shift != PS2_EXT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            timer   <= '0;
        end else begin
            timer   <= (state == IDLE || fall) ? '0 : timer + 1'b1;
            bit_cnt <= (state == DATA && fall) ? bit_cnt + 1'b1 : (state == IDLE ? '0 : bit_cnt);
            shift   <= (state == DATA && fall) ? {data_s, shift[7:1]} : shift;
            par_bit <= (state == PARITY && fall) ? data_s : par_bit;
        end
    end

    // a publish coinciding with read_ack wins: the new event stays valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code      <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            ferr      <= 1'b0;
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            flap_held <= 1'b0;
        end else begin
            code      <= publish ? shift : code;
            brk       <= publish ? brk_pend : brk;
            ext       <= publish ? ext_pend : ext;
            valid     <= publish ? 1'b1 : (read_ack ? 1'b0 : valid);
            overrun   <= publish ? (valid && !read_ack) : (read_ack ? 1'b0 : overrun);
            ferr      <= bad ? 1'b1 : (read_ack ? 1'b0 : ferr);
            brk_pend  <= (publish || bad) ? 1'b0 : ((good && shift == PS2_BREAK) ? 1'b1 : brk_pend);
            ext_pend  <= (publish || bad) ? 1'b0 : ((good && shift == PS2_EXT) ? 1'b1 : ext_pend);
            if (publish && shift == FLAP_CODE)
                flap_held <= brk_pend ? 1'b0 : (ext_pend ? flap_held : 1'b1);
        end
    end

    always_comb begin
        ps2_read                  = '0;
        ps2_read[7:0]             = code;
        ps2_read[PS2_BREAK_BIT]   = brk;
        ps2_read[PS2_EXT_BIT]     = ext;
        ps2_read[PS2_VALID_BIT]   = valid;
        ps2_read[PS2_OVERRUN_BIT] = overrun;
        ps2_read[PS2_FERR_BIT]    = ferr;
    end
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb_ps2_keyboard_receiver: directed PS/2 frames with a queue of expected
// status words, checked by a monitor whenever the outputs change.
`timescale 1ns/1ps
module tb_ps2_keyboard_receiver;
    logic        clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, read_ack = 0;
    logic [31:0] ps2_read;
    logic        flap_held;
    int          compared = 0, mismatched = 0, exp_id = 0;

    typedef struct {
        logic [31:0] word;
        logic        flap;
        int          id;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic        mon_en = 0;
    logic [32:0] prev = '0;

    always #10 clk = ~clk;

    ps2_keyboard_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1000), .FLAP_CODE(8'h29)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .read_ack(read_ack), .ps2_read(ps2_read), .flap_held(flap_held)
    );

    always @(negedge clk) begin
        if (mon_en && {flap_held, ps2_read} !== prev) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_change: got ps2_read=%h flap=%b, expected no change", ps2_read, flap_held);
            end else begin
                e = q.pop_front();
                if (ps2_read !== e.word || flap_held !== e.flap) begin
                    mismatched++;
                    $display("FAIL event%0d: got ps2_read=%h flap=%b, expected ps2_read=%h flap=%b",
                             e.id, ps2_read, flap_held, e.word, e.flap);
                end
            end
        end
        prev = {flap_held, ps2_read};
    end

    task automatic expect_out(input logic [31:0] w, input logic f);
        q.push_back('{w, f, exp_id});
        exp_id++;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (50) @(posedge clk);
        ps2_clk = 0;
        repeat (100) @(posedge clk);
        ps2_clk = 1;
        repeat (50) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] c, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit(~^c ^ bad_par);
        ps2_bit(1'b1);
    endtask

    task automatic ack();
        @(posedge clk); #1 read_ack = 1;
        @(posedge clk); #1 read_ack = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending events, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        compared++;
        if (ps2_read !== 32'h0 || flap_held !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: got ps2_read=%h flap=%b, expected 0 0", ps2_read, flap_held);
        end
        rst = 0;
        mon_en = 1;
        repeat (5) @(posedge clk);
        // single make code, then acknowledge
        expect_out(32'h41C, 0); send(8'h1C, 0); drain();
        expect_out(32'h01C, 0); ack(); drain();
        // break prefix: one publish only
        expect_out(32'h51C, 0); send(8'hF0, 0); send(8'h1C, 0); drain();
        expect_out(32'h11C, 0); ack(); drain();
        // extended + break
        expect_out(32'h76B, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0); drain();
        expect_out(32'h36B, 0); ack(); drain();
        // flap key press and release
        expect_out(32'h429, 1); send(8'h29, 0); drain();
        expect_out(32'h029, 1); ack(); drain();
        expect_out(32'h529, 0); send(8'hF0, 0); send(8'h29, 0); drain();
        expect_out(32'h129, 0); ack(); drain();
        // overrun, then parity error keeps [10:0]
        expect_out(32'h41C, 0); send(8'h1C, 0); drain();
        expect_out(32'hC32, 0); send(8'h32, 0); drain();
        expect_out(32'h1C32, 0); send(8'h55, 1); drain();
        expect_out(32'h032, 0); ack(); drain();
        // timeout after four data bits, then a normal frame
        expect_out(32'h1032, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (1200) @(posedge clk);
        drain();
        expect_out(32'h1429, 1); send(8'h29, 0); drain();
        expect_out(32'h029, 1); ack(); drain();
        // reset mid-frame
        expect_out(32'h0, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        ps2_clk = 0;
        repeat (20) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        compared++;
        if (ps2_read !== 32'h0 || flap_held !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: got ps2_read=%h flap=%b, expected 0 0", ps2_read, flap_held);
        end
        ps2_clk = 1;
        ps2_data = 1;
        repeat (5) @(posedge clk);
        rst = 0;
        drain();
        expect_out(32'h41C, 0); send(8'h1C, 0); drain();
        repeat (20) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 4 ms");
        $fatal(1);
    end
endmodule
